// File: rtl/wavelet_pkg.sv
// Shared constants, FSM state type and coefficient-table helpers for the
// Ricker-wavelet MAC scheduler.
package wavelet_pkg;

    localparam int unsigned NUM_FILTERS_DEFAULT = 7;
    localparam int unsigned TOTAL_COEFS         = 187;

    localparam int unsigned FILT_LEN  [7] = '{3, 5, 9, 15, 27, 47, 81};
    localparam int unsigned FILT_BASE [7] = '{0, 3, 8, 17, 32, 59, 106};

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        RUN,
        DRAIN
    } state_t;

    // Out-of-table filter numbers yield 0 so the lookups stay total.
    function automatic int unsigned filt_len(input int unsigned f);
        return (f < 7) ? FILT_LEN[f] : 0;
    endfunction

    function automatic int unsigned filt_base(input int unsigned f);
        return (f < 7) ? FILT_BASE[f] : 0;
    endfunction

endpackage

// File: rtl/wavelet_mac_scheduler_if.sv
// Sample-pin, MAC-issue and result-bank signals of the wavelet MAC scheduler.
interface wavelet_mac_scheduler_if #(
    parameter int unsigned IDX_BITS = 10,
    parameter int unsigned SEL_BITS = 3
);
    logic                i_data_clk;
    logic                i_enable;
    logic                i_clear_err;
    logic                o_shift;
    logic                o_mac_valid;
    logic                o_mac_clear;
    logic                o_mac_last;
    logic [IDX_BITS-1:0] o_tap_idx;
    logic [IDX_BITS-1:0] o_coef_addr;
    logic [SEL_BITS-1:0] o_filter_sel;
    logic                o_result_we;
    logic [SEL_BITS-1:0] o_result_sel;
    logic                o_busy;
    logic                o_frame_done;
    logic                o_overrun;

    modport master (
        input  i_data_clk, i_enable, i_clear_err,
        output o_shift, o_mac_valid, o_mac_clear, o_mac_last, o_tap_idx,
               o_coef_addr, o_filter_sel, o_result_we, o_result_sel,
               o_busy, o_frame_done, o_overrun
    );

    modport slave (
        output i_data_clk, i_enable, i_clear_err,
        input  o_shift, o_mac_valid, o_mac_clear, o_mac_last, o_tap_idx,
               o_coef_addr, o_filter_sel, o_result_we, o_result_sel,
               o_busy, o_frame_done, o_overrun
    );
endinterface

// File: rtl/sample_strobe_sync.sv
// Two-flop synchronizer plus rising-edge detector for an asynchronous pin strobe.
module sample_strobe_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic pin,
    output logic rise
);
    logic s1, s2, s3;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
            s3 <= 1'b0;
        end else begin
            s1 <= pin;
            s2 <= s1;
            s3 <= s2;
        end
    end

    assign rise = s2 & ~s3;
endmodule

// File: rtl/wavelet_mac_scheduler.sv
// Walks every wavelet filter's taps through one shared MAC per sample strobe
// and strobes each filter's accumulator result into the output bank.
module wavelet_mac_scheduler
    import wavelet_pkg::*;
#(
    parameter int unsigned NUM_FILTERS = NUM_FILTERS_DEFAULT,
    parameter int unsigned IDX_BITS    = 10,
    parameter int unsigned SEL_BITS    = 3,
    parameter int unsigned MAC_LAT     = 2
) (
    input logic                    clk,
    input logic                    rst_n,
    wavelet_mac_scheduler_if.master bus
);
    localparam int unsigned CNT_BITS = (MAC_LAT > 1) ? $clog2(MAC_LAT) : 1;

    state_t              state, state_n;
    logic [SEL_BITS-1:0] f, f_n;
    logic [IDX_BITS-1:0] k, k_n;
    logic [CNT_BITS-1:0] cnt, cnt_n;
    logic                rise, run, last, overrun;

    logic                dl_last [MAC_LAT];
    logic [SEL_BITS-1:0] dl_sel  [MAC_LAT];

    sample_strobe_sync u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .pin   (bus.i_data_clk),
        .rise  (rise)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            f     <= '0;
            k     <= '0;
            cnt   <= '0;
        end else begin
            state <= state_n;
            f     <= f_n;
            k     <= k_n;
            cnt   <= cnt_n;
        end
    end

    always_comb begin
        state_n = state;
        f_n     = f;
        k_n     = k;
        cnt_n   = cnt;
        last    = (32'(k) == filt_len(32'(f)) - 1);
        case (state)
            IDLE:  if (rise && bus.i_enable) state_n = SHIFT;
            SHIFT: begin
                f_n     = '0;
                k_n     = '0;
                state_n = RUN;
            end
            RUN: begin
                if (!last) begin
                    k_n = k + IDX_BITS'(1);
                end else if (32'(f) == NUM_FILTERS - 1) begin
                    cnt_n   = '0;
                    state_n = DRAIN;
                end else begin
                    f_n = f + SEL_BITS'(1);
                    k_n = '0;
                end
            end
            DRAIN: begin
                if (32'(cnt) == MAC_LAT - 1) state_n = IDLE;
                else                         cnt_n   = cnt + CNT_BITS'(1);
            end
            default: state_n = IDLE;
        endcase
    end

    assign run              = (state == RUN);
    assign bus.o_shift      = (state == SHIFT);
    assign bus.o_busy       = (state != IDLE);
    assign bus.o_mac_valid  = run;
    assign bus.o_mac_clear  = run && (k == '0);
    assign bus.o_mac_last   = run && last;
    assign bus.o_tap_idx    = run ? k : '0;
    assign bus.o_coef_addr  = run ? IDX_BITS'(filt_base(32'(f)) + 32'(k)) : '0;
    assign bus.o_filter_sel = run ? f : '0;

    // {last, f} travels alongside the MAC pipeline so the bank write lines up
    // with the accumulator result MAC_LAT cycles after the last tap.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < MAC_LAT; i++) begin
                dl_last[i] <= 1'b0;
                dl_sel[i]  <= '0;
            end
        end else begin
            dl_last[0] <= bus.o_mac_last;
            dl_sel[0]  <= bus.o_mac_last ? f : '0;
            for (int unsigned i = 1; i < MAC_LAT; i++) begin
                dl_last[i] <= dl_last[i-1];
                dl_sel[i]  <= dl_sel[i-1];
            end
        end
    end

    assign bus.o_result_we  = dl_last[MAC_LAT-1];
    assign bus.o_result_sel = dl_sel[MAC_LAT-1];
    assign bus.o_frame_done = dl_last[MAC_LAT-1] &&
                              (32'(dl_sel[MAC_LAT-1]) == NUM_FILTERS - 1);

    // A set in the same cycle as a clear takes priority.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                        overrun <= 1'b0;
        else if (rise && state != IDLE)    overrun <= 1'b1;
        else if (bus.i_clear_err)          overrun <= 1'b0;
    end

    assign bus.o_overrun = overrun;
endmodule
